// File: rtl/garage_input_cond_if.sv
// Signal bundle between the raw wall inputs and the garage door motor controller.
// The raw-input source holds the master side; the conditioning stage holds the slave side.
interface garage_input_cond_if;
    logic btn_raw;
    logic up_sw_raw;
    logic dn_sw_raw;
    logic activate;
    logic up_max;
    logic dn_max;
    logic sw_fault;

    modport master (
        output btn_raw, up_sw_raw, dn_sw_raw,
        input  activate, up_max, dn_max, sw_fault
    );

    modport slave (
        input  btn_raw, up_sw_raw, dn_sw_raw,
        output activate, up_max, dn_max, sw_fault
    );
endinterface

// File: rtl/garage_input_cond.sv
// Synchronises and debounces the wall button and both limit switches, turns each clean
// press into a single activate pulse with re-trigger lockout, and latches a both-limits fault.
module garage_input_cond #(
    parameter int DB_CYCLES      = 4,
    parameter int LOCKOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    garage_input_cond_if.slave    bus
);
    localparam int BTN = 0;
    localparam int UP  = 1;
    localparam int DN  = 2;

    typedef enum logic [1:0] {IDLE, PRESSED, LOCKOUT} state_t;

    logic [2:0]       raw;
    logic [2:0]       sync1;
    logic [2:0]       sync2;
    logic [2:0]       stable;
    logic [2:0]       lvl;
    logic [CNT_W-1:0] db_cnt [3];
    logic             btn_lvl_d;
    logic             btn_rise;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] lock_cnt;
    logic [CNT_W-1:0] lock_cnt_next;
    logic             fire;
    logic             activate_q;
    logic             fault_q;

    assign raw = {bus.dn_sw_raw, bus.up_sw_raw, bus.btn_raw};

    // Three identical channels: two-flop synchroniser, debounce counter, registered level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= '0;
            sync2     <= '0;
            stable    <= '0;
            lvl       <= '0;
            btn_lvl_d <= 1'b0;
            // NOTE: the counter array is a handful of flops, not a RAM, so it is cleared
            // explicitly; a reset must abort any debounce already in progress.
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values;
            // blocking here would collapse the synchroniser into a single stage.
            sync1     <= raw;
            sync2     <= sync1;
            lvl       <= stable;
            btn_lvl_d <= lvl[BTN];
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] + CNT_W'(1) == CNT_W'(DB_CYCLES)) begin
                    stable[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign btn_rise = lvl[BTN] & ~btn_lvl_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lock_cnt   <= '0;
            activate_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state      <= state_next;
            lock_cnt   <= lock_cnt_next;
            activate_q <= fire;
            fault_q    <= fault_q | (stable[UP] & stable[DN]);
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        state_next    = state;
        lock_cnt_next = lock_cnt;
        if (fault_q) begin
            state_next    = IDLE;
            lock_cnt_next = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (btn_rise) state_next = PRESSED;
                end
                PRESSED: begin
                    if (!lvl[BTN]) begin
                        if (LOCKOUT_CYCLES == 0) begin
                            state_next = IDLE;
                        end else begin
                            state_next    = LOCKOUT;
                            lock_cnt_next = CNT_W'(LOCKOUT_CYCLES);
                        end
                    end
                end
                LOCKOUT: begin
                    if (lock_cnt <= CNT_W'(1)) begin
                        state_next    = IDLE;
                        lock_cnt_next = '0;
                    end else begin
                        lock_cnt_next = lock_cnt - CNT_W'(1);
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        fire = (state == IDLE) && btn_rise && !fault_q;
    end

    // A latched fault pins both limits high so the motor halts in either direction.
    assign bus.activate = activate_q & ~fault_q;
    assign bus.up_max   = lvl[UP] | fault_q;
    assign bus.dn_max   = lvl[DN] | fault_q;
    assign bus.sw_fault = fault_q;
endmodule

// File: tb/tb_garage_input_cond.sv
// Scoreboard bench for garage_input_cond: expected activate edges are queued when a press
// is driven and consumed by a monitor whenever the DUT pulses activate.
module tb_garage_input_cond;
    localparam int DB = 4;
    localparam int LO = 16;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   edge_n = 0;
    int   checks = 0;
    int   failures = 0;
    int   exp_q[$];
    int   exp_edge;

    garage_input_cond_if bus();

    garage_input_cond #(
        .DB_CYCLES(DB),
        .LOCKOUT_CYCLES(LO),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    // Every activate pulse must match the oldest queued expectation edge-for-edge.
    always @(negedge clk) begin
        if (bus.activate === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL activate_unexpected: got pulse at edge %0d, required none", edge_n);
            end else begin
                exp_edge = exp_q.pop_front();
                if (exp_edge != edge_n) begin
                    failures++;
                    $display("FAIL activate_time: got edge %0d, required edge %0d", edge_n, exp_edge);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called on the negedge the press is driven: first sampling edge +1, pulse DB+3 later.
    task automatic expect_press();
        exp_q.push_back(edge_n + 1 + DB + 3);
    endtask

    task automatic drain(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_missing_pulse: got %0d pulses outstanding, required 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        bus.btn_raw = 1'b0; bus.up_sw_raw = 1'b0; bus.dn_sw_raw = 1'b0;
        rst = 1'b1;
        step(3);
        checks += 4;
        if (bus.activate !== 1'b0) begin failures++; $display("FAIL reset_activate: got %b, required 0", bus.activate); end
        if (bus.up_max   !== 1'b0) begin failures++; $display("FAIL reset_up_max: got %b, required 0", bus.up_max); end
        if (bus.dn_max   !== 1'b0) begin failures++; $display("FAIL reset_dn_max: got %b, required 0", bus.dn_max); end
        if (bus.sw_fault !== 1'b0) begin failures++; $display("FAIL reset_sw_fault: got %b, required 0", bus.sw_fault); end
    endtask

    task automatic test_single_press();
        rst = 1'b0;
        bus.btn_raw = 1'b1;
        expect_press();
        for (int c = 0; c < 20; c++) begin
            step(1);
            checks += 3;
            if (bus.up_max   !== 1'b0) begin failures++; $display("FAIL press_up_max: got %b, required 0", bus.up_max); end
            if (bus.dn_max   !== 1'b0) begin failures++; $display("FAIL press_dn_max: got %b, required 0", bus.dn_max); end
            if (bus.sw_fault !== 1'b0) begin failures++; $display("FAIL press_sw_fault: got %b, required 0", bus.sw_fault); end
        end
        bus.btn_raw = 1'b0;
        step(30);
        drain("single_press");
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 10; i++) begin
            bus.btn_raw = (i % 2 == 0);
            step(1);
        end
        bus.btn_raw = 1'b1;
        expect_press();
        step(20);
        bus.btn_raw = 1'b0;
        step(30);
        drain("bounce");
    endtask

    task automatic test_lockout();
        bus.btn_raw = 1'b1;
        expect_press();
        step(10);
        bus.btn_raw = 1'b0;        // level falls 7 edges later, lockout follows
        step(12);
        bus.btn_raw = 1'b1;        // re-press lands inside lockout: ignored
        step(4);
        bus.btn_raw = 1'b0;
        step(11);
        bus.btn_raw = 1'b1;        // 20 cycles after the level fell: accepted
        expect_press();
        step(10);
        bus.btn_raw = 1'b0;
        step(30);
        drain("lockout");
    endtask

    task automatic test_limits();
        bit exp_lvl;
        bus.up_sw_raw = 1'b1;
        step(3);
        bus.up_sw_raw = 1'b0;
        for (int c = 0; c < 15; c++) begin
            step(1);
            checks++;
            if (bus.up_max !== 1'b0) begin failures++; $display("FAIL glitch_up_max: got %b, required 0", bus.up_max); end
        end
        bus.up_sw_raw = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            step(1);
            exp_lvl = (c >= 7 && c < 17);
            checks += 2;
            if (bus.up_max !== exp_lvl) begin failures++; $display("FAIL level_up_max c=%0d: got %b, required %b", c, bus.up_max, exp_lvl); end
            if (bus.dn_max !== 1'b0) begin failures++; $display("FAIL level_dn_max c=%0d: got %b, required 0", c, bus.dn_max); end
            if (c == 10) bus.up_sw_raw = 1'b0;
        end
        // Button and lower switch change together; both outputs follow their own latency.
        bus.btn_raw = 1'b1;
        bus.dn_sw_raw = 1'b1;
        expect_press();
        for (int c = 1; c <= 10; c++) begin
            step(1);
            exp_lvl = (c >= 7);
            checks++;
            if (bus.dn_max !== exp_lvl) begin failures++; $display("FAIL simul_dn_max c=%0d: got %b, required %b", c, bus.dn_max, exp_lvl); end
        end
        bus.btn_raw = 1'b0;
        bus.dn_sw_raw = 1'b0;
        step(30);
        checks++;
        if (bus.dn_max !== 1'b0) begin failures++; $display("FAIL simul_dn_release: got %b, required 0", bus.dn_max); end
        drain("limits");
    endtask

    task automatic test_fault();
        bit exp_f;
        bus.up_sw_raw = 1'b1;
        bus.dn_sw_raw = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            step(1);
            exp_f = (c >= 7);
            checks++;
            if (bus.sw_fault !== exp_f) begin failures++; $display("FAIL fault_set c=%0d: got %b, required %b", c, bus.sw_fault, exp_f); end
        end
        bus.btn_raw = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step(1);
            checks += 3;
            if (bus.activate !== 1'b0) begin failures++; $display("FAIL fault_activate: got %b, required 0", bus.activate); end
            if (bus.up_max   !== 1'b1) begin failures++; $display("FAIL fault_up_max: got %b, required 1", bus.up_max); end
            if (bus.dn_max   !== 1'b1) begin failures++; $display("FAIL fault_dn_max: got %b, required 1", bus.dn_max); end
        end
        bus.btn_raw = 1'b0;
        bus.up_sw_raw = 1'b0;
        bus.dn_sw_raw = 1'b0;
        for (int c = 0; c < 15; c++) begin
            step(1);
            checks += 3;
            if (bus.sw_fault !== 1'b1) begin failures++; $display("FAIL fault_sticky: got %b, required 1", bus.sw_fault); end
            if (bus.up_max   !== 1'b1) begin failures++; $display("FAIL fault_sticky_up: got %b, required 1", bus.up_max); end
            if (bus.dn_max   !== 1'b1) begin failures++; $display("FAIL fault_sticky_dn: got %b, required 1", bus.dn_max); end
        end
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        checks += 4;
        if (bus.sw_fault !== 1'b0) begin failures++; $display("FAIL fault_clear: got %b, required 0", bus.sw_fault); end
        if (bus.up_max   !== 1'b0) begin failures++; $display("FAIL fault_clear_up: got %b, required 0", bus.up_max); end
        if (bus.dn_max   !== 1'b0) begin failures++; $display("FAIL fault_clear_dn: got %b, required 0", bus.dn_max); end
        if (bus.activate !== 1'b0) begin failures++; $display("FAIL fault_clear_act: got %b, required 0", bus.activate); end
        step(20);
        drain("fault");
    endtask

    task automatic test_reset_in_lockout();
        bus.btn_raw = 1'b1;
        expect_press();
        step(10);
        bus.btn_raw = 1'b0;
        step(12);                  // lockout now in progress
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        checks += 4;
        if (bus.activate !== 1'b0) begin failures++; $display("FAIL midrst_activate: got %b, required 0", bus.activate); end
        if (bus.up_max   !== 1'b0) begin failures++; $display("FAIL midrst_up_max: got %b, required 0", bus.up_max); end
        if (bus.dn_max   !== 1'b0) begin failures++; $display("FAIL midrst_dn_max: got %b, required 0", bus.dn_max); end
        if (bus.sw_fault !== 1'b0) begin failures++; $display("FAIL midrst_sw_fault: got %b, required 0", bus.sw_fault); end
        bus.btn_raw = 1'b1;
        expect_press();
        step(10);
        bus.btn_raw = 1'b0;
        step(30);
        drain("reset_in_lockout");
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_lockout();
        test_limits();
        test_fault();
        test_reset_in_lockout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
